mfp_ahb_lite_adc_max10: RTL
===========================

MFP_AHB_LITE_ADC_MAX10 -- requirements
Module: mfp_ahb_lite_adc_max10

Interface
REQ-001 Parameter: ADDR_WIDTH, default 4, width of the register-bus word address (equals the ADC core register address width).
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RESETn  input  1  reset; synchronous, active-low.
REQ-004 HSEL  input  1  slave select from AHB-Lite decoder.
REQ-005 HADDR  input  32  byte address; bits [ADDR_WIDTH+1:2] select register, higher bits ignored.
REQ-006 HTRANS  input  2  transfer type; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-007 HWRITE  input  1  1=write, 0=read.
REQ-008 HSIZE  input  3  transfer size; only 3'b010 (word) legal.
REQ-009 HREADY  input  1  bus-level ready; address phase sampled only when high.
REQ-010 HWDATA  input  32  write data, valid in data phase.
REQ-011 HRDATA  output  32  read data, valid in data phase.
REQ-012 HREADYOUT  output  1  slave ready.
REQ-013 HRESP  output  1  0=OKAY, 1=ERROR.
REQ-014 read_addr  output  ADDR_WIDTH  register-bus read address to ADC core.
REQ-015 read_data  input  32  combinational read data from ADC core.
REQ-016 write_addr  output  ADDR_WIDTH  register-bus write address.
REQ-017 write_data  output  32  register-bus write data.
REQ-018 write_enable  output  1  one-cycle register write strobe.

Function
REQ-019 Transfer accepted on an edge where HSEL & HREADY & HTRANS[1]; IDLE/BUSY, HSEL=0 or HREADY=0 SHALL cause no transfer.
REQ-020 Accepted transfer legal iff HSIZE==3'b010 and HADDR[1:0]==2'b00; illegal otherwise.
REQ-021 On acceptance, HADDR[ADDR_WIDTH+1:2] SHALL be latched into addr_q.
REQ-022 FSM states: IDLE, READ, WRITE, ERR1, ERR2; next state chosen on every edge where HREADY is high.
REQ-023 From IDLE/READ/WRITE/ERR2: legal read -> READ; legal write -> WRITE; illegal -> ERR1; no transfer -> IDLE.
REQ-024 ERR1 -> ERR2 unconditionally; ERR1 SHALL NOT sample a new address phase.
REQ-025 HREADYOUT SHALL be 0 in ERR1, 1 in all other states (zero-wait-state OKAY transfers).
REQ-026 HRESP SHALL be 1 in ERR1 and ERR2, 0 otherwise (two-cycle AHB ERROR response).
REQ-027 read_addr SHALL equal addr_q in READ, else the current HADDR[ADDR_WIDTH+1:2].
REQ-028 HRDATA SHALL equal read_data in READ, 32'h0 otherwise.
REQ-029 write_enable SHALL be 1 exactly in WRITE state; write_addr=addr_q; write_data=HWDATA, unregistered.
REQ-030 Illegal transfers SHALL never assert write_enable; illegal reads return HRDATA=0.
REQ-031 Write followed immediately by read of same register SHALL return the newly written value (core updates at end of WRITE cycle).
REQ-032 Pipelined back-to-back transfers (address phase N+1 during data phase N) SHALL sustain one transfer per cycle.

Reset
REQ-033 While RESETn=0 at an edge: state=IDLE, addr_q=0; thus HREADYOUT=1, HRESP=0, write_enable=0, HRDATA=0.
REQ-034 Reset during a WRITE or ERR data phase SHALL abort it; no write_enable after reset edge.

Verification
REQ-035 NONSEQ word write HADDR=0x00, HWDATA=0x00000013 -> next cycle write_enable=1, write_addr=0, write_data=0x13, HREADYOUT=1, HRESP=0.
REQ-036 Write HADDR=0x04 data 0x7F then pipelined read HADDR=0x04 -> write_enable one cycle, then read_addr=1, HRDATA=read_data (0x7F from core model).
REQ-037 Byte write (HSIZE=000) HADDR=0x08 -> HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1, write_enable never asserted.
REQ-038 HTRANS=BUSY, HSEL=0, or HREADY=0 with otherwise valid write -> state stays IDLE, write_enable=0.
REQ-039 Unaligned read HADDR=0x06 followed by legal read 0x0C in ERR2 -> error response, then READ with read_addr=3.
REQ-040 RESETn=0 asserted in WRITE data phase -> next cycle write_enable=0, HREADYOUT=1, HRESP=0, HRDATA=0.

Source files
------------

// File: rtl/mfp_ahb_lite_adc_max10_if.sv
// AHB-Lite slave-side bus bundle for the MAX10 ADC register bridge.
// Ports: address phase (HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY),
//        data phase (HWDATA in, HRDATA/HREADYOUT/HRESP back to the bus).
interface mfp_ahb_lite_adc_max10_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/mfp_ahb_lite_adc_max10.sv
// AHB-Lite to ADC core register-bus bridge (word accesses only).
// Latency: zero-wait-state OKAY transfers; illegal ones get a 2-cycle ERROR.
// Backpressure: HREADYOUT low only in the first ERROR cycle.
// Ports: CLK, RESETn (sync, active-low); ahb (slave modport);
//        read_addr/read_data  - combinational register read path to the core;
//        write_addr/write_data/write_enable - one-cycle register write strobe.
module mfp_ahb_lite_adc_max10 #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                      CLK,
  input  logic                      RESETn,
  mfp_ahb_lite_adc_max10_if.slave   ahb,
  output logic [ADDR_WIDTH-1:0]     read_addr,
  input  logic [31:0]               read_data,
  output logic [ADDR_WIDTH-1:0]     write_addr,
  output logic [31:0]               write_data,
  output logic                      write_enable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  accept;
  logic                  legal;
  logic [ADDR_WIDTH-1:0] haddr_word;

  // Upper address bits are decoded by the interconnect, not here.
  logic unused_haddr;
  assign unused_haddr = ^ahb.HADDR[31:ADDR_WIDTH+2];

  assign haddr_word = ahb.HADDR[ADDR_WIDTH+1:2];
  assign accept     = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign legal      = (ahb.HSIZE == 3'b010) && (ahb.HADDR[1:0] == 2'b00);

  // State register and captured data-phase address.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      // ERR1 drives HREADYOUT low, so any address phase seen there is not ours to take.
      if (accept && state_q != S_ERR1)
        addr_q <= haddr_word;
    end
  end

  // Next state. ERR1 advances without HREADY: the bus is stalled by our own
  // HREADYOUT=0 in that cycle, so waiting on HREADY would deadlock.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (ahb.HREADY) begin
          if (!accept)
            state_d = S_IDLE;
          else if (!legal)
            state_d = S_ERR1;
          else if (ahb.HWRITE)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
    endcase
  end

  // Outputs. Outside a read data phase the read address follows the live
  // bus address so the core's combinational read path is already settled.
  always_comb begin
    ahb.HREADYOUT = 1'b1;
    ahb.HRESP     = 1'b0;
    ahb.HRDATA    = 32'h0;
    write_enable  = 1'b0;
    read_addr     = haddr_word;
    case (state_q)
      S_READ: begin
        read_addr  = addr_q;
        ahb.HRDATA = read_data;
      end
      S_WRITE: write_enable = 1'b1;
      S_ERR1: begin
        ahb.HREADYOUT = 1'b0;
        ahb.HRESP     = 1'b1;
      end
      S_ERR2: ahb.HRESP = 1'b1;
      default: ;
    endcase
  end

  assign write_addr = addr_q;
  assign write_data = ahb.HWDATA;

endmodule
